pattern_matcher_window: RTL and testbench

- Parametrised successor to the byte pattern comparator.
- Hunts an incoming word stream for a programmable PLEN-word sync pattern, then asserts WREN for exactly PAYLOAD_LEN following valid words so a downstream buffer captures the payload.
- Re-arms automatically; sits between the sampled data bus and the capture RAM write port.

---
 rtl/pattern_matcher_pkg.sv | 19 +
 rtl/pm_shift_window.sv | 70 +++++++
 rtl/pattern_matcher_window.sv | 93 +++++++++
 tb/tb_pattern_matcher_window.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/pattern_matcher_pkg.sv
// Shared types and defaults for the windowed sync-pattern matcher.
package pattern_matcher_pkg;

    localparam int DW_DEF   = 8;
    localparam int PLEN_DEF = 2;
    localparam int LW_DEF   = 8;

    typedef enum logic {
        HUNT    = 1'b0,
        CAPTURE = 1'b1
    } pm_state_e;

    // Word 0 is the first word expected on the bus, i.e. the top slice of pat.
    function automatic logic [DW_DEF-1:0] word_at(input logic [PLEN_DEF*DW_DEF-1:0] pat,
                                                   input int unsigned i);
        return pat[(PLEN_DEF-1-i)*DW_DEF +: DW_DEF];
    endfunction

endpackage

// File: rtl/pm_shift_window.sv
// Sliding window of the last PLEN valid words (PLEN-1 stored plus the live DBUS word)
// with fill qualification; PATTERN_MASK_EN adds a per-bit don't-care mask to the compare.
import pattern_matcher_pkg::*;

module pm_shift_window #(
    parameter int DW   = DW_DEF,
    parameter int PLEN = PLEN_DEF
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    input  logic                 dvalid_i,
    input  logic [DW-1:0]        dbus_i,
    input  logic [PLEN*DW-1:0]   pat_i,
`ifdef PATTERN_MASK_EN
    input  logic [PLEN*DW-1:0]   pat_mask_i,
`endif
    input  logic                 clear_i,
    output logic                 hit_o
);

    logic [PLEN*DW-1:0] cand;
    logic               fill_ok;

    generate
        if (PLEN > 1) begin : g_multi
            localparam int FW = (PLEN > 2) ? $clog2(PLEN) : 1;
            localparam logic [FW-1:0] FILL_MAX = FW'(PLEN - 1);

            logic [(PLEN-1)*DW-1:0] hist_q, hist_d;
            logic [FW-1:0]          fill_q, fill_d;

            assign cand    = {hist_q, dbus_i};
            assign fill_ok = (fill_q == FILL_MAX);

            always_comb begin
                hist_d = hist_q;
                fill_d = fill_q;
                if (clear_i) begin
                    hist_d = '0;
                    fill_d = '0;
                end else if (dvalid_i) begin
                    hist_d = cand[(PLEN-1)*DW-1:0];
                    if (fill_q != FILL_MAX) begin
                        fill_d = fill_q + 1'b1;
                    end
                end
            end

            always_ff @(posedge clk_i) begin
                if (!rst_n_i) begin
                    hist_q <= '0;
                    fill_q <= '0;
                end else begin
                    hist_q <= hist_d;
                    fill_q <= fill_d;
                end
            end
        end else begin : g_single
            assign cand    = dbus_i;
            assign fill_ok = 1'b1;
        end
    endgenerate

`ifdef PATTERN_MASK_EN
    assign hit_o = fill_ok && (((cand ^ pat_i) & pat_mask_i) == '0);
`else
    assign hit_o = fill_ok && (cand == pat_i);
`endif

endmodule

// File: rtl/pattern_matcher_window.sv
// Hunts for a PLEN-word sync pattern, then raises WREN for PAYLOAD_LEN valid words.
// Define PATTERN_MASK_EN to add the PAT_MASK don't-care input.
import pattern_matcher_pkg::*;

module pattern_matcher_window #(
    parameter int DW   = DW_DEF,
    parameter int PLEN = PLEN_DEF,
    parameter int LW   = LW_DEF
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [DW-1:0]        DBUS,
    input  logic                 DVALID,
    input  logic [PLEN*DW-1:0]   PAT,
    input  logic [LW-1:0]        PAYLOAD_LEN,
`ifdef PATTERN_MASK_EN
    input  logic [PLEN*DW-1:0]   PAT_MASK,
`endif
    output logic                 WREN,
    output logic                 MATCH,
    output logic                 BUSY,
    output logic [LW-1:0]        PCOUNT
);

    pm_state_e     state_q, state_d;
    logic          match_q, match_d;
    logic [LW-1:0] pcount_q, pcount_d;
    logic          win_clear;
    logic          hit;

    pm_shift_window #(
        .DW   (DW),
        .PLEN (PLEN)
    ) u_window (
        .clk_i      (CLK),
        .rst_n_i    (RST),
        .dvalid_i   (DVALID),
        .dbus_i     (DBUS),
        .pat_i      (PAT),
`ifdef PATTERN_MASK_EN
        .pat_mask_i (PAT_MASK),
`endif
        .clear_i    (win_clear),
        .hit_o      (hit)
    );

    always_comb begin
        state_d   = state_q;
        match_d   = 1'b0;
        pcount_d  = pcount_q;
        win_clear = 1'b0;
        case (state_q)
            HUNT: begin
                if (DVALID && hit) begin
                    match_d  = 1'b1;
                    pcount_d = PAYLOAD_LEN;
                    if (PAYLOAD_LEN != '0) begin
                        state_d = CAPTURE;
                    end
                end
            end
            CAPTURE: begin
                // Payload words are data only; the window fills but its hit is ignored here.
                if (DVALID) begin
                    pcount_d = pcount_q - 1'b1;
                    if (pcount_q == LW'(1)) begin
                        state_d   = HUNT;
                        win_clear = 1'b1;
                    end
                end
            end
            default: state_d = HUNT;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q  <= HUNT;
            match_q  <= 1'b0;
            pcount_q <= '0;
        end else begin
            state_q  <= state_d;
            match_q  <= match_d;
            pcount_q <= pcount_d;
        end
    end

    assign BUSY   = (state_q == CAPTURE);
    assign WREN   = BUSY & DVALID;
    assign MATCH  = match_q;
    assign PCOUNT = pcount_q;

endmodule

// File: tb/tb_pattern_matcher_window.sv
// Table-driven scoreboard bench for pattern_matcher_window; covers the PATTERN_MASK_EN
// case when that macro is defined.
module tb_pattern_matcher_window;
    import pattern_matcher_pkg::*;

    localparam int DW   = 8;
    localparam int PLEN = 2;
    localparam int LW   = 8;

    logic                 CLK = 1'b0;
    logic                 RST = 1'b0;
    logic [DW-1:0]        DBUS = '0;
    logic                 DVALID = 1'b0;
    logic [PLEN*DW-1:0]   PAT = 16'hAA55;
    logic [LW-1:0]        PAYLOAD_LEN = '0;
`ifdef PATTERN_MASK_EN
    logic [PLEN*DW-1:0]   PAT_MASK = '1;
`endif
    logic                 WREN, MATCH, BUSY;
    logic [LW-1:0]        PCOUNT;

    pattern_matcher_window #(.DW(DW), .PLEN(PLEN), .LW(LW)) dut (
        .CLK         (CLK),
        .RST         (RST),
        .DBUS        (DBUS),
        .DVALID      (DVALID),
        .PAT         (PAT),
        .PAYLOAD_LEN (PAYLOAD_LEN),
`ifdef PATTERN_MASK_EN
        .PAT_MASK    (PAT_MASK),
`endif
        .WREN        (WREN),
        .MATCH       (MATCH),
        .BUSY        (BUSY),
        .PCOUNT      (PCOUNT)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int         tid;
        logic       rst;
        logic [15:0] pat;
        logic [7:0] plen;
        logic       dv;
        logic [7:0] d;
        logic       ew;
        logic       em;
        logic       eb;
        logic [7:0] epc;
    } vec_t;

    vec_t vecs[$];
    vec_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic check(input string nm, input int tid, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s (test %0d): got %0h, expected %0h", nm, tid, act, exp);
        end
    endtask

    task automatic add(input int tid, input logic rst, input logic [15:0] pat, input logic [7:0] plen,
                       input logic dv, input logic [7:0] d,
                       input logic ew, input logic em, input logic eb, input logic [7:0] epc);
        vec_t v;
        v.tid = tid; v.rst = rst; v.pat = pat; v.plen = plen; v.dv = dv; v.d = d;
        v.ew = ew; v.em = em; v.eb = eb; v.epc = epc;
        vecs.push_back(v);
    endtask

    // Drive one cycle: WREN is sampled before the edge, registered outputs after it.
    task automatic apply(input vec_t v);
        vec_t e;
        logic wren_s;
        RST         = ~v.rst;
        PAT         = v.pat;
        PAYLOAD_LEN = v.plen;
        DVALID      = v.dv;
        DBUS        = v.d;
        exp_q.push_back(v);
        #1;
        wren_s = WREN;
        @(posedge CLK);
        #1;
        e = exp_q.pop_front();
        check("WREN",   e.tid, {31'b0, wren_s}, {31'b0, e.ew});
        check("MATCH",  e.tid, {31'b0, MATCH},  {31'b0, e.em});
        check("BUSY",   e.tid, {31'b0, BUSY},   {31'b0, e.eb});
        check("PCOUNT", e.tid, {24'b0, PCOUNT}, {24'b0, e.epc});
    endtask

    initial begin
        logic [15:0] P;
        logic [7:0]  W0, W1;
        P  = 16'hAA55;
        W0 = word_at(P, 0);
        W1 = word_at(P, 1);

        // Basic capture; trailing AA restarts the hunt
        add(1,1,P,3,0,0,     0,0,0,0);
        add(1,0,P,3,1,8'h11, 0,0,0,0);
        add(1,0,P,3,1,W0,    0,0,0,0);
        add(1,0,P,3,1,W1,    0,1,1,3);
        add(1,0,P,3,1,8'h40, 1,0,1,2);
        add(1,0,P,3,1,8'h33, 1,0,1,1);
        add(1,0,P,3,1,8'h76, 1,0,0,0);
        add(1,0,P,3,1,W0,    0,0,0,0);
        add(1,0,P,3,0,0,     0,0,0,0);
        // Overlapping pattern
        add(2,1,P,3,0,0,     0,0,0,0);
        add(2,0,P,3,1,W0,    0,0,0,0);
        add(2,0,P,3,1,W0,    0,0,0,0);
        add(2,0,P,3,1,W1,    0,1,1,3);
        add(2,0,P,3,0,0,     0,0,1,3);
        // Stall gap inside capture
        add(3,1,P,2,0,0,     0,0,0,0);
        add(3,0,P,2,1,W0,    0,0,0,0);
        add(3,0,P,2,1,W1,    0,1,1,2);
        add(3,0,P,2,0,0,     0,0,1,2);
        add(3,0,P,2,0,0,     0,0,1,2);
        add(3,0,P,2,0,0,     0,0,1,2);
        add(3,0,P,2,1,8'h13, 1,0,1,1);
        add(3,0,P,2,1,8'h20, 1,0,0,0);
        // Pattern inside payload is data only
        add(4,1,P,2,0,0,     0,0,0,0);
        add(4,0,P,2,1,W0,    0,0,0,0);
        add(4,0,P,2,1,W1,    0,1,1,2);
        add(4,0,P,2,1,W0,    1,0,1,1);
        add(4,0,P,2,1,W1,    1,0,0,0);
        add(4,0,P,2,1,8'h28, 0,0,0,0);
        // Zero-length payload: two matches, no writes
        add(5,1,P,0,0,0,     0,0,0,0);
        add(5,0,P,0,1,W0,    0,0,0,0);
        add(5,0,P,0,1,W1,    0,1,0,0);
        add(5,0,P,0,1,W0,    0,0,0,0);
        add(5,0,P,0,1,W1,    0,1,0,0);
        // All-zero pattern needs a full window; back-to-back matches with length 0
        add(6,1,16'h0000,0,0,0, 0,0,0,0);
        add(6,0,16'h0000,0,1,0, 0,0,0,0);
        add(6,0,16'h0000,0,1,0, 0,1,0,0);
        add(6,0,16'h0000,0,1,0, 0,1,0,0);
        add(6,0,16'h0000,0,0,0, 0,0,0,0);

        RST = 1'b0;
        @(posedge CLK);
        #1;
        check("reset PCOUNT", 0, {24'b0, PCOUNT}, 32'd0);
        check("reset BUSY",   0, {31'b0, BUSY},   32'd0);

        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i]);
        end

        // Reset mid-capture aborts and clears the window
        begin
            vec_t v;
            v.pat = P; v.plen = 8'd3; v.tid = 7;
            v.rst = 1; v.dv = 0; v.d = 0;     v.ew = 0; v.em = 0; v.eb = 0; v.epc = 0; apply(v);
            v.rst = 0; v.dv = 1; v.d = W0;    v.ew = 0; v.em = 0; v.eb = 0; v.epc = 0; apply(v);
            v.rst = 0; v.dv = 1; v.d = W1;    v.ew = 0; v.em = 1; v.eb = 1; v.epc = 3; apply(v);
            v.rst = 0; v.dv = 1; v.d = 8'h40; v.ew = 1; v.em = 0; v.eb = 1; v.epc = 2; apply(v);
            v.rst = 1; v.dv = 0; v.d = 0;     v.ew = 0; v.em = 0; v.eb = 0; v.epc = 0; apply(v);
            v.rst = 0; v.dv = 1; v.d = W1;    v.ew = 0; v.em = 0; v.eb = 0; v.epc = 0; apply(v);
            v.rst = 0; v.dv = 1; v.d = W0;    v.ew = 0; v.em = 0; v.eb = 0; v.epc = 0; apply(v);
            v.rst = 0; v.dv = 1; v.d = W1;    v.ew = 0; v.em = 1; v.eb = 1; v.epc = 3; apply(v);
        end

`ifdef PATTERN_MASK_EN
        begin
            vec_t v;
            PAT_MASK = 16'hFF00;
            v.pat = P; v.plen = 8'd0; v.tid = 8;
            v.rst = 1; v.dv = 0; v.d = 0;     v.ew = 0; v.em = 0; v.eb = 0; v.epc = 0; apply(v);
            v.rst = 0; v.dv = 1; v.d = 8'hAA; v.ew = 0; v.em = 0; v.eb = 0; v.epc = 0; apply(v);
            v.rst = 0; v.dv = 1; v.d = 8'hBB; v.ew = 0; v.em = 1; v.eb = 0; v.epc = 0; apply(v);
            v.rst = 0; v.dv = 1; v.d = 8'hAB; v.ew = 0; v.em = 0; v.eb = 0; v.epc = 0; apply(v);
            v.rst = 0; v.dv = 1; v.d = 8'h55; v.ew = 0; v.em = 0; v.eb = 0; v.epc = 0; apply(v);
            PAT_MASK = '1;
        end
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
